uart_reg_bridge: RTL
====================

// Module: uart_reg_bridge
// PURPOSE
// - Sequences uart_rx_tx for host-PC register access: parses received UART bytes into
//   read/write commands, drives the FPGA register bus, serialises the response via the UART TX.
// - Sits between the uart_rx_tx byte interface and the register space; sole owner of the UART TX.
// PARAMETERS
// - BYTE_TIMEOUT  100000  max sys_clk cycles between bytes of one request before the frame is dropped
// - RD_TIMEOUT    255     max cycles from reg_rd_en to reg_rd_valid before the read is an error
// PORTS
// - sys_clk       in   1   single clock; all logic on rising edge
// - sys_rst       in   1   synchronous, active-high reset
// - rx_dvalid     in   1   1-cycle pulse: rx_data valid (from UART RX)
// - rx_data       in   8   received byte
// - tx_status     in   1   UART TX busy (high from accept until TX returns idle)
// - tx_dvalid     out  1   1-cycle pulse: request UART to send tx_data
// - tx_data       out  8   byte to send; held stable until send completes
// - reg_wr_en     out  1   1-cycle register write strobe
// - reg_rd_en     out  1   1-cycle register read strobe
// - reg_addr      out  8   register address
// - reg_wdata     out  32  write data
// - reg_rdata     in   32  read data, sampled when reg_rd_valid=1
// - reg_rd_valid  in   1   read data valid
// - busy          out  1   high in any state other than IDLE
// - err_cnt       out  8   saturating count of protocol errors
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters cleared. Reset mid-frame abandons it; a UART byte
//   already in flight still completes in the UART (it has no reset).
// - Request: cmd, addr, [4 data bytes MSB first if write]. cmd 0x57 'W' = write, 0x52 'R' = read.
// - Response: write -> 0x4B 'K'; read -> 4 bytes MSB first; any error -> 0x45 'E'.
// - States: IDLE -> GET_ADDR -> (W: GET_DATA x4 | R: REG_RD) ; GET_DATA -> REG_WR ;
//   REG_RD -> WAIT_RD ; REG_WR/WAIT_RD -> TX_LOAD -> TX_WAIT_BUSY -> TX_WAIT_DONE ->
//   (next response byte: TX_LOAD | last byte: IDLE).
// - IDLE: a rx_dvalid byte other than 'W'/'R' -> queue 'E', err_cnt+1.
// - REG_WR: reg_wr_en high exactly 1 cycle, addr/wdata valid that cycle; 'K' queued next cycle.
// - REG_RD: reg_rd_en high 1 cycle; WAIT_RD captures reg_rdata on first reg_rd_valid.
//   reg_rd_valid in the same cycle as reg_rd_en is captured. No valid within RD_TIMEOUT -> 'E', err_cnt+1.
// - TX handshake: TX_LOAD drives tx_data and pulses tx_dvalid 1 cycle; TX_WAIT_BUSY waits
//   tx_status=1; TX_WAIT_DONE waits tx_status=0; tx_data unchanged throughout (UART samples late).
//   Back-to-back response bytes: next tx_dvalid no earlier than 1 cycle after tx_status falls.
// - Byte timeout: counter clears on every accepted byte; reaching BYTE_TIMEOUT in GET_* -> IDLE,
//   err_cnt+1, no response. rx_dvalid in the same cycle as timeout expiry: byte wins.
// - rx_dvalid outside IDLE/GET_*: byte dropped, err_cnt+1, current operation unaffected.
// - err_cnt saturates at 255; multiple error sources in one cycle count as one.
// - Latency: last request byte -> tx_dvalid for write = 3 cycles (REG_WR, TX_LOAD, pulse).
// CONFIGURATION
// - UART_BRIDGE_CSUM_EN defined: request carries trailing checksum byte = XOR of all prior
//   request bytes (state GET_CSUM before REG_WR/REG_RD); mismatch -> 'E', err_cnt+1, no bus
//   access. Every response ends with XOR-of-response-bytes checksum byte.
// - Undefined: no checksum byte in either direction; GET_CSUM state absent.
// TESTING
// - Rx 57 10 DE AD BE EF -> one reg_wr_en, addr 0x10, wdata 0xDEADBEEF; tx 4B; busy low after.
// - Rx 52 20, reg_rd_valid 5 cycles after reg_rd_en with rdata 0x12345678 -> tx 12 34 56 78, tx_data stable per byte.
// - Rx 52 30, reg_rd_valid never -> tx 45 after RD_TIMEOUT cycles; err_cnt=1.
// - Rx 57 10 AA then silence > BYTE_TIMEOUT -> no bus strobe, no tx, IDLE, err_cnt+1; following 52 20 served normally.
// - Rx 0x41 -> tx 45, err_cnt+1; 300 invalid bytes -> err_cnt=255.
// - CSUM_EN: rx 52 20 72 -> read performed, tx 4 bytes + XOR; rx 52 20 00 -> tx 45 + 45, no reg_rd_en.

Source files
------------

// File: rtl/uart_reg_bridge.sv
// UART byte-stream to register-bus bridge: parses 'W'/'R' requests, drives the bus, sends replies.
// Optional request/response checksum byte enabled by defining UART_BRIDGE_CSUM_EN.
module uart_reg_bridge #(
    parameter int unsigned BYTE_TIMEOUT = 100000,
    parameter int unsigned RD_TIMEOUT   = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        rx_dvalid,
    input  logic [7:0]  rx_data,
    input  logic        tx_status,
    output logic        tx_dvalid,
    output logic [7:0]  tx_data,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata,
    input  logic        reg_rd_valid,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] CmdWr = 8'h57;
    localparam logic [7:0] CmdRd = 8'h52;
    localparam logic [7:0] RspOk = 8'h4B;
    localparam logic [7:0] RspEr = 8'h45;

`ifdef UART_BRIDGE_CSUM_EN
    localparam logic [2:0] CsumLen = 3'd1;
    typedef enum logic [3:0] {
        StIdle, StGetAddr, StGetData, StGetCsum, StRegWr, StRegRd, StWaitRd,
        StTxLoad, StTxWaitBusy, StTxWaitDone
    } state_e;
`else
    localparam logic [2:0] CsumLen = 3'd0;
    typedef enum logic [3:0] {
        StIdle, StGetAddr, StGetData, StRegWr, StRegRd, StWaitRd,
        StTxLoad, StTxWaitBusy, StTxWaitDone
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  data_cnt_q, data_cnt_d;
    logic [31:0] resp_q, resp_d;
    logic [2:0]  resp_len_q, resp_len_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_dvalid_q, tx_dvalid_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        err_inc;
    logic        accepting;
    logic [7:0]  tx_byte;
`ifdef UART_BRIDGE_CSUM_EN
    logic [7:0]  rx_csum_q, rx_csum_d;
    logic [7:0]  tx_csum_q, tx_csum_d;
    localparam state_e StAfterAddrRd = StGetCsum;
    localparam state_e StAfterData   = StGetCsum;
`else
    localparam state_e StAfterAddrRd = StRegRd;
    localparam state_e StAfterData   = StRegWr;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_cnt_d  = data_cnt_q;
        resp_d      = resp_q;
        resp_len_d  = resp_len_q;
        tx_idx_d    = tx_idx_q;
        tx_data_d   = tx_data_q;
        tx_dvalid_d = 1'b0;
        err_inc     = 1'b0;
        tx_byte     = resp_q[31:24];
`ifdef UART_BRIDGE_CSUM_EN
        rx_csum_d   = rx_csum_q;
        tx_csum_d   = tx_csum_q;
`endif
        accepting = (state_q == StIdle) || (state_q == StGetAddr) || (state_q == StGetData);
`ifdef UART_BRIDGE_CSUM_EN
        accepting = accepting || (state_q == StGetCsum);
`endif

        case (state_q)
            StIdle: begin
                if (rx_dvalid) begin
                    if (rx_data == CmdWr || rx_data == CmdRd) begin
                        is_wr_d = (rx_data == CmdWr);
                        timer_d = '0;
                        state_d = StGetAddr;
`ifdef UART_BRIDGE_CSUM_EN
                        rx_csum_d = rx_data;
`endif
                    end else begin
                        err_inc    = 1'b1;
                        resp_d     = {RspEr, 24'h0};
                        resp_len_d = 3'd1;
                        state_d    = StTxLoad;
                    end
                end
            end
            StGetAddr: begin
                if (rx_dvalid) begin
                    addr_d     = rx_data;
                    timer_d    = '0;
                    data_cnt_d = '0;
                    state_d    = is_wr_q ? StGetData : StAfterAddrRd;
`ifdef UART_BRIDGE_CSUM_EN
                    rx_csum_d = rx_csum_q ^ rx_data;
`endif
                end else if (timer_q == 32'(BYTE_TIMEOUT - 1)) begin
                    err_inc = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StGetData: begin
                if (rx_dvalid) begin
                    wdata_d    = {wdata_q[23:0], rx_data};
                    data_cnt_d = data_cnt_q + 2'd1;
                    timer_d    = '0;
                    if (data_cnt_q == 2'd3) state_d = StAfterData;
`ifdef UART_BRIDGE_CSUM_EN
                    rx_csum_d = rx_csum_q ^ rx_data;
`endif
                end else if (timer_q == 32'(BYTE_TIMEOUT - 1)) begin
                    err_inc = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
`ifdef UART_BRIDGE_CSUM_EN
            StGetCsum: begin
                if (rx_dvalid) begin
                    if (rx_data == rx_csum_q) begin
                        state_d = is_wr_q ? StRegWr : StRegRd;
                    end else begin
                        err_inc    = 1'b1;
                        resp_d     = {RspEr, 24'h0};
                        resp_len_d = 3'd1;
                        state_d    = StTxLoad;
                    end
                end else if (timer_q == 32'(BYTE_TIMEOUT - 1)) begin
                    err_inc = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
`endif
            StRegWr: begin
                resp_d     = {RspOk, 24'h0};
                resp_len_d = 3'd1;
                state_d    = StTxLoad;
            end
            StRegRd: begin
                // Timer counts cycles since the read strobe.
                timer_d = 32'd1;
                if (reg_rd_valid) begin
                    resp_d     = reg_rdata;
                    resp_len_d = 3'd4;
                    state_d    = StTxLoad;
                end else begin
                    state_d = StWaitRd;
                end
            end
            StWaitRd: begin
                if (reg_rd_valid) begin
                    resp_d     = reg_rdata;
                    resp_len_d = 3'd4;
                    state_d    = StTxLoad;
                end else if (timer_q >= 32'(RD_TIMEOUT)) begin
                    err_inc    = 1'b1;
                    resp_d     = {RspEr, 24'h0};
                    resp_len_d = 3'd1;
                    state_d    = StTxLoad;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StTxLoad: begin
`ifdef UART_BRIDGE_CSUM_EN
                if (tx_idx_q == resp_len_q) tx_byte = tx_csum_q;
                tx_csum_d = ((tx_idx_q == 3'd0) ? 8'h00 : tx_csum_q) ^ tx_byte;
`endif
                tx_data_d   = tx_byte;
                tx_dvalid_d = 1'b1;
                resp_d      = resp_q << 8;
                tx_idx_d    = tx_idx_q + 3'd1;
                state_d     = StTxWaitBusy;
            end
            StTxWaitBusy: begin
                if (tx_status) state_d = StTxWaitDone;
            end
            StTxWaitDone: begin
                if (!tx_status) begin
                    if (tx_idx_q == resp_len_q + CsumLen) begin
                        tx_idx_d = '0;
                        state_d  = StIdle;
                    end else begin
                        state_d = StTxLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (rx_dvalid && !accepting) err_inc = 1'b1;
        err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_cnt_q  <= '0;
            resp_q      <= '0;
            resp_len_q  <= '0;
            tx_idx_q    <= '0;
            tx_data_q   <= '0;
            tx_dvalid_q <= 1'b0;
            err_cnt_q   <= '0;
`ifdef UART_BRIDGE_CSUM_EN
            rx_csum_q   <= '0;
            tx_csum_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_cnt_q  <= data_cnt_d;
            resp_q      <= resp_d;
            resp_len_q  <= resp_len_d;
            tx_idx_q    <= tx_idx_d;
            tx_data_q   <= tx_data_d;
            tx_dvalid_q <= tx_dvalid_d;
            err_cnt_q   <= err_cnt_d;
`ifdef UART_BRIDGE_CSUM_EN
            rx_csum_q   <= rx_csum_d;
            tx_csum_q   <= tx_csum_d;
`endif
        end
    end

    assign tx_dvalid = tx_dvalid_q;
    assign tx_data   = tx_data_q;
    assign reg_wr_en = (state_q == StRegWr);
    assign reg_rd_en = (state_q == StRegRd);
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign busy      = (state_q != StIdle);
    assign err_cnt   = err_cnt_q;

endmodule
